// File: rtl/brush_stamper.sv
// -----------------------------------------------------------------------------
// brush_stamper
//   Draw-path write sequencer. While the pen is down, each new cursor position
//   becomes a burst of framebuffer writes covering a square brush of
//   half-extent r (clipped to the screen). It also runs full-screen clears and
//   arbitrates them against stamps. It owns the single framebuffer write port
//   through a valid/ready handshake.
//
//   Optional feature macro: BRUSH_ROUND_EN
//     defined   : pixels with dx^2+dy^2 > r^2 are skipped (one idle cycle each)
//     undefined : full square brush, no squarer logic
//
// Ports
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   draw_en_in         pen down (level)
//   clear_in           clear request, rising edge counts
//   cursor_x_in/_y_in  cursor position (clamped to the screen)
//   color_in           brush colour
//   stroke_width_in    brush half-extent r (0..7)
//   wr_valid_out / wr_ready_in / wr_addr_out / wr_data_out
//                      framebuffer write handshake, address = y*H_RES+x
//   busy_out           sequencer not idle
//   stamp_done_out     one-cycle pulse after a stamp or clear completes
// -----------------------------------------------------------------------------
module brush_stamper #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 360,
    parameter int COLOR_W = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               draw_en_in,
    input  logic               clear_in,
    input  logic [9:0]         cursor_x_in,
    input  logic [8:0]         cursor_y_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic [2:0]         stroke_width_in,
    output logic               wr_valid_out,
    input  logic               wr_ready_in,
    output logic [17:0]        wr_addr_out,
    output logic [COLOR_W-1:0] wr_data_out,
    output logic               busy_out,
    output logic               stamp_done_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_STAMP, ST_CLEAR} state_t;

    localparam logic [10:0] X_MAX     = 11'(H_RES - 1);
    localparam logic [9:0]  Y_MAX     = 10'(V_RES - 1);
    localparam logic [17:0] LAST_ADDR = 18'(H_RES * V_RES - 1);

    state_t state_q, state_d;

    logic               clear_prev_q, pending_q;
    logic               last_valid_q, done_q;
    logic [9:0]         last_x_q;
    logic [8:0]         last_y_q;
    logic [COLOR_W-1:0] color_q;
    logic [9:0]         x_lo_q, x_hi_q, x_q;
    logic [8:0]         y_hi_q, y_q;
    logic [17:0]        addr_q;

    // ---------------- stamp set-up (evaluated while idle) ----------------
    logic [9:0]         cx_c;
    logic [8:0]         cy_c;
    logic signed [10:0] x_lo_s, x_hi_s;
    logic signed [9:0]  y_lo_s, y_hi_s;
    logic [9:0]         x_lo_c, x_hi_c;
    logic [8:0]         y_lo_c, y_hi_c;
    logic [17:0]        start_addr_c;

    assign cx_c = ({1'b0, cursor_x_in} > X_MAX) ? X_MAX[9:0] : cursor_x_in;
    assign cy_c = ({1'b0, cursor_y_in} > Y_MAX) ? Y_MAX[8:0] : cursor_y_in;

    assign x_lo_s = $signed({1'b0, cx_c}) - $signed({8'd0, stroke_width_in});
    assign x_hi_s = $signed({1'b0, cx_c}) + $signed({8'd0, stroke_width_in});
    assign y_lo_s = $signed({1'b0, cy_c}) - $signed({7'd0, stroke_width_in});
    assign y_hi_s = $signed({1'b0, cy_c}) + $signed({7'd0, stroke_width_in});

    assign x_lo_c = x_lo_s[10] ? 10'd0 : x_lo_s[9:0];
    assign x_hi_c = (x_hi_s > $signed(X_MAX)) ? X_MAX[9:0] : x_hi_s[9:0];
    assign y_lo_c = y_lo_s[9] ? 9'd0 : y_lo_s[8:0];
    assign y_hi_c = (y_hi_s > $signed(Y_MAX)) ? Y_MAX[8:0] : y_hi_s[8:0];

    // Only the first pixel address is computed with a product; the scan
    // itself advances the address by additions.
    assign start_addr_c = 18'(y_lo_c) * 18'(H_RES) + 18'(x_lo_c);

    // ---------------- scan control ----------------
    logic        clear_rise, trig, in_shape;
    logic        row_end, stamp_last, stamp_adv, clear_xfer, clear_last;
    logic [17:0] row_step;

    assign clear_rise = clear_in & ~clear_prev_q;
    assign trig       = draw_en_in &&
                        (!last_valid_q || cx_c != last_x_q || cy_c != last_y_q);
    assign row_end    = (x_q == x_hi_q);
    assign stamp_last = row_end && (y_q == y_hi_q);
    // A skipped (out-of-shape) pixel advances without waiting for ready.
    assign stamp_adv  = (state_q == ST_STAMP) && (!in_shape || wr_ready_in);
    assign clear_xfer = (state_q == ST_CLEAR) && wr_ready_in;
    assign clear_last = (addr_q == LAST_ADDR);
    // Jump from the row end back to the left edge of the next row.
    assign row_step   = 18'(H_RES) - 18'(x_hi_q - x_lo_q);

`ifdef BRUSH_ROUND_EN
    logic [9:0]         cx_q;
    logic [8:0]         cy_q;
    logic [2:0]         r_q;
    logic signed [21:0] dx_w, dy_w, dist_sq, r_sq;

    assign dx_w    = 22'($signed({1'b0, x_q}) - $signed({1'b0, cx_q}));
    assign dy_w    = 22'($signed({2'b0, y_q}) - $signed({2'b0, cy_q}));
    assign dist_sq = dx_w * dx_w + dy_w * dy_w;
    assign r_sq    = $signed({19'd0, r_q}) * $signed({19'd0, r_q});
    assign in_shape = (dist_sq <= r_sq);
`else
    assign in_shape = 1'b1;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q || clear_rise) state_d = ST_CLEAR;
                else if (trig)               state_d = ST_STAMP;
            end
            ST_STAMP: if (stamp_adv && stamp_last)  state_d = ST_IDLE;
            ST_CLEAR: if (clear_xfer && clear_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        wr_valid_out = 1'b0;
        wr_data_out  = '0;
        case (state_q)
            ST_STAMP: begin
                wr_valid_out = in_shape;
                wr_data_out  = color_q;
            end
            ST_CLEAR: wr_valid_out = 1'b1;
            default: ;
        endcase
    end

    assign wr_addr_out    = addr_q;
    assign busy_out       = (state_q != ST_IDLE);
    assign stamp_done_out = done_q;

    // ---------------- datapath / bookkeeping ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clear_prev_q <= 1'b0;
            pending_q    <= 1'b0;
            last_valid_q <= 1'b0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            done_q       <= 1'b0;
            color_q      <= '0;
            x_lo_q       <= '0;
            x_hi_q       <= '0;
            x_q          <= '0;
            y_hi_q       <= '0;
            y_q          <= '0;
            addr_q       <= '0;
`ifdef BRUSH_ROUND_EN
            cx_q         <= '0;
            cy_q         <= '0;
            r_q          <= '0;
`endif
        end else begin
            clear_prev_q <= clear_in;

            // Edges seen during a clear are dropped; entering CLEAR consumes
            // the request.
            if (state_q == ST_IDLE && state_d == ST_CLEAR) pending_q <= 1'b0;
            else if (clear_rise && state_q != ST_CLEAR)    pending_q <= 1'b1;

            done_q <= (stamp_adv && stamp_last) || (clear_xfer && clear_last);

            if (!draw_en_in || (clear_xfer && clear_last)) last_valid_q <= 1'b0;
            else if (state_q == ST_IDLE && state_d == ST_STAMP) last_valid_q <= 1'b1;

            if (state_q == ST_IDLE && state_d == ST_STAMP) begin
                last_x_q <= cx_c;
                last_y_q <= cy_c;
                color_q  <= color_in;
                x_lo_q   <= x_lo_c;
                x_hi_q   <= x_hi_c;
                y_hi_q   <= y_hi_c;
                x_q      <= x_lo_c;
                y_q      <= y_lo_c;
                addr_q   <= start_addr_c;
`ifdef BRUSH_ROUND_EN
                cx_q     <= cx_c;
                cy_q     <= cy_c;
                r_q      <= stroke_width_in;
`endif
            end else if (state_q == ST_IDLE && state_d == ST_CLEAR) begin
                addr_q <= '0;
            end else if (stamp_adv) begin
                if (row_end) begin
                    x_q    <= x_lo_q;
                    y_q    <= y_q + 9'd1;
                    addr_q <= addr_q + row_step;
                end else begin
                    x_q    <= x_q + 10'd1;
                    addr_q <= addr_q + 18'd1;
                end
            end else if (clear_xfer) begin
                addr_q <= addr_q + 18'd1;
            end
        end
    end

endmodule

// File: tb/tb_brush_stamper.sv
module tb_brush_stamper;

    // Screen height reduced so a full clear stays a few tens of thousands of
    // cycles; width keeps the native 640 columns.
    localparam int H     = 640;
    localparam int V     = 48;
    localparam int CW    = 4;
    localparam int TOTAL = H * V;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b1;
    logic          draw_en_in = 1'b0;
    logic          clear_in = 1'b0;
    logic [9:0]    cursor_x_in = '0;
    logic [8:0]    cursor_y_in = '0;
    logic [CW-1:0] color_in = '0;
    logic [2:0]    stroke_width_in = '0;
    logic          wr_valid_out;
    logic          wr_ready_in = 1'b1;
    logic [17:0]   wr_addr_out;
    logic [CW-1:0] wr_data_out;
    logic          busy_out;
    logic          stamp_done_out;

    brush_stamper #(.H_RES(H), .V_RES(V), .COLOR_W(CW)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .draw_en_in      (draw_en_in),
        .clear_in        (clear_in),
        .cursor_x_in     (cursor_x_in),
        .cursor_y_in     (cursor_y_in),
        .color_in        (color_in),
        .stroke_width_in (stroke_width_in),
        .wr_valid_out    (wr_valid_out),
        .wr_ready_in     (wr_ready_in),
        .wr_addr_out     (wr_addr_out),
        .wr_data_out     (wr_data_out),
        .busy_out        (busy_out),
        .stamp_done_out  (stamp_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   exp_done = 0;
    int   xfer_count = 0;
    int   ready_mode = 0;   // 0: always ready, 1: toggle, 2: random

    // Reference model of the stamp history
    bit   last_valid_m = 0;
    int   last_x_m = 0;
    int   last_y_m = 0;

    // ---------------- reference model ----------------
    task automatic push_stamp(input int xr, input int yr, input int r, input int c);
        int cx, cy, x0, x1, y0, y1;
        cx = (xr >= H) ? H - 1 : xr;
        cy = (yr >= V) ? V - 1 : yr;
        if (last_valid_m && cx == last_x_m && cy == last_y_m) return;
        last_valid_m = 1;
        last_x_m = cx;
        last_y_m = cy;
        x0 = (cx - r < 0) ? 0 : cx - r;
        x1 = (cx + r > H - 1) ? H - 1 : cx + r;
        y0 = (cy - r < 0) ? 0 : cy - r;
        y1 = (cy + r > V - 1) ? V - 1 : cy + r;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
`ifdef BRUSH_ROUND_EN
                if ((x - cx) * (x - cx) + (y - cy) * (y - cy) > r * r) continue;
`endif
                q.push_back('{y * H + x, c});
            end
        end
        exp_done++;
    endtask

    task automatic push_clear();
        for (int a = 0; a < TOTAL; a++) q.push_back('{a, 0});
        exp_done++;
        last_valid_m = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input int x, input int y, input int r, input int c);
        draw_en_in      = 1'b1;
        cursor_x_in     = 10'(x);
        cursor_y_in     = 9'(y);
        stroke_width_in = 3'(r);
        color_in        = CW'(c);
        push_stamp(x, y, r, c);
    endtask

    task automatic wait_done(input int target, input int budget, input bit chk_empty);
        int k;
        k = 0;
        while (done_count < target && k < budget) begin
            cyc(1);
            k++;
        end
        checks++;
        if (done_count < target) begin
            errors++;
            $display("FAIL done_timeout: done pulses %0d, required %0d", done_count, target);
        end
        if (chk_empty) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL missing_writes: %0d expected writes not seen, required 0", q.size());
                q.delete();
            end
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            case (ready_mode)
                0:       wr_ready_in = 1'b1;
                1:       wr_ready_in = ~wr_ready_in;
                default: wr_ready_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          hold_pending;
        bit          prev_done;
        logic [17:0] h_addr;
        logic [CW-1:0] h_data;
        exp_t        e;
        hold_pending = 0;
        prev_done = 0;
        h_addr = '0;
        h_data = '0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                hold_pending = 0;
                prev_done = 0;
            end else begin
                if (hold_pending) begin
                    checks++;
                    if (!wr_valid_out || wr_addr_out != h_addr || wr_data_out != h_data) begin
                        errors++;
                        $display("FAIL hold_stable: valid %0b addr %0d data %0d, required valid 1 addr %0d data %0d",
                                 wr_valid_out, wr_addr_out, wr_data_out, h_addr, h_data);
                    end
                end
                hold_pending = wr_valid_out && !wr_ready_in;
                h_addr = wr_addr_out;
                h_data = wr_data_out;

                if (wr_valid_out && wr_ready_in) begin
                    xfer_count++;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data %0d, required no write",
                                 wr_addr_out, wr_data_out);
                    end else begin
                        e = q.pop_front();
                        if (int'(wr_addr_out) != e.addr || int'(wr_data_out) != e.data) begin
                            errors++;
                            $display("FAIL write: addr %0d data %0d, required addr %0d data %0d",
                                     wr_addr_out, wr_data_out, e.addr, e.data);
                        end
                    end
                end

                if (stamp_done_out) begin
                    done_count++;
                    checks++;
                    if (wr_valid_out || prev_done) begin
                        errors++;
                        $display("FAIL done_pulse: valid %0b prev_done %0b, required 0 0",
                                 wr_valid_out, prev_done);
                    end
                end
                prev_done = stamp_done_out;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int base, x, y, r, c, px, py;

        // Reset: outputs must be zero without a clock edge
        #2 rst_n_in = 1'b0;
        #1;
        check_bit("rst_valid", wr_valid_out, 1'b0);
        check_bit("rst_busy", busy_out, 1'b0);
        check_bit("rst_done", stamp_done_out, 1'b0);
        checks++;
        if (wr_addr_out != 0 || wr_data_out != 0) begin
            errors++;
            $display("FAIL rst_addr_data: addr %0d data %0d, required 0 0", wr_addr_out, wr_data_out);
        end
        cyc(3);
        rst_n_in = 1'b1;
        cyc(2);

        // Single pixel with latency check
        ready_mode = 0;
        issue(100, 20, 0, 5);
        @(posedge clk_in);
        @(negedge clk_in);
        check_bit("latency_valid", wr_valid_out, 1'b1);
        checks++;
        if (wr_addr_out != 18'(20 * H + 100)) begin
            errors++;
            $display("FAIL single_addr: got %0d, required %0d", wr_addr_out, 20 * H + 100);
        end
        wait_done(exp_done, 50, 1);
        cyc(20);   // static cursor: any write here is unexpected
        checks++;
        if (xfer_count != 1) begin
            errors++;
            $display("FAIL single_count: got %0d writes, required 1", xfer_count);
        end

        // Clip at origin
        issue(0, 0, 1, 7);
        wait_done(exp_done, 50, 1);
        // Clip at far corner
        issue(H - 1, V - 1, 2, 3);
        wait_done(exp_done, 50, 1);
        // Clamped coordinates, same clamped position as before -> no stamp
        issue(1000, 500, 2, 3);
        wait_done(exp_done, 50, 1);
        cyc(10);

        // Backpressure: ready toggles every cycle during an r=3 stamp
        ready_mode = 1;
        base = xfer_count;
        issue(200, 24, 3, 9);
        wait_done(exp_done, 400, 1);
        checks++;
        if (xfer_count - base != 49) begin
            errors++;
            $display("FAIL backpressure_count: got %0d, required 49", xfer_count - base);
        end

        // Randomized stamps with mid-burst input scrambling
        ready_mode = 2;
        px = 0;
        py = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                x = px;
                y = py;
            end else begin
                x = $urandom_range(0, 700);
                y = $urandom_range(0, V + 8);
            end
            r = $urandom_range(0, 7);
            c = $urandom_range(0, 15);
            px = x;
            py = y;
            issue(x, y, r, c);
            cyc(2);
            color_in        = CW'($urandom_range(0, 15));
            stroke_width_in = 3'($urandom_range(0, 7));
            wait_done(exp_done, 3000, 1);
        end

        // Clear arbitration: clear pulsed mid-stamp
        ready_mode = 0;
        issue(300, 20, 7, 9);
        cyc(3);
        clear_in = 1'b1;
        cyc(1);
        clear_in = 1'b0;
        push_clear();
        push_stamp(300, 20, 7, 9);     // held pen re-stamps after the clear
        wait_done(exp_done - 2, 1000, 0);
        cyc(50);
        check_bit("busy_in_clear", busy_out, 1'b1);
        clear_in = 1'b1;               // edge during CLEAR is ignored
        cyc(1);
        clear_in = 1'b0;
        wait_done(exp_done, 40000, 1);
        cyc(20);

        // Async reset mid-clear
        draw_en_in = 1'b0;
        last_valid_m = 0;
        cyc(2);
        clear_in = 1'b1;
        cyc(1);
        clear_in = 1'b0;
        push_clear();
        cyc(100);
        check_bit("clear_running", busy_out, 1'b1);
        @(posedge clk_in);
        #3 rst_n_in = 1'b0;
        #1;
        check_bit("arst_valid", wr_valid_out, 1'b0);
        check_bit("arst_busy", busy_out, 1'b0);
        checks++;
        if (wr_addr_out != 0) begin
            errors++;
            $display("FAIL arst_addr: got %0d, required 0", wr_addr_out);
        end
        q.delete();
        exp_done--;
        cyc(2);
        rst_n_in = 1'b1;
        cyc(2);
        check_bit("post_rst_idle", busy_out, 1'b0);
        check_bit("post_rst_valid", wr_valid_out, 1'b0);

        // Operation resumes after reset
        issue(5, 5, 1, 3);
        wait_done(exp_done, 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
